// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the command-RAM front end: the sequencer FSM state
// encoding and the two-bit opcodes carried on ram_din[MSB:MSB-1].
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADDR    = 2'd1,
    S_DATA    = 2'd2,
    S_WAIT_RD = 2'd3
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_FIRE = 2'b11;

endpackage : ram_ctrl_pkg

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: starting at i_ptr and wrapping
// modulo NUM_REQ, the first asserted request wins. The pointer itself is
// owned and advanced by the parent.
// Ports:
//   i_req   [NUM_REQ]  request vector
//   i_ptr   [IDW]      index searched first
//   i_en    1          grant enable; no grant when low
//   o_grant [NUM_REQ]  one-hot grant (all zero if none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant
);

  logic w_found;
  int   w_idx;

  // NOTE: every variable written in an always_comb gets a default on entry,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_REQ;
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single-port command RAM between NUM_REQ requesters. One
// transaction at a time is accepted (round-robin) and expanded into the RAM's
// two-beat sequence: address beat, then data / read-fire beat. Read data is
// returned with the owning port's ID; a read that sees no ram_tx_valid within
// RD_TIMEOUT cycles completes with rsp_err.
//
// Optional feature (macro ADDR_REUSE_EN): remember the last write address and
// last read address sent to the RAM; a request that hits the remembered
// address for its op type skips the address beat.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/ready/rd   per-port handshake and op (1 = read)
//   req_addr/req_wdata   per-port payload, port i at [i*W +: W]
//   rsp_valid/id/rdata/err  registered one-cycle completion
//   ram_din/ram_rx_valid command to the RAM ({opcode, payload})
//   ram_dout/ram_tx_valid   read data back from the RAM
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int NUM_REQ    = 2,
  parameter int RD_TIMEOUT = 4,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_rd,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wdata,
  output logic                           rsp_valid,
  output logic [IDW-1:0]                 rsp_id,
  output logic [MEM_WIDTH-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic [MEM_WIDTH+1:0]           ram_din,
  output logic                           ram_rx_valid,
  input  logic [MEM_WIDTH-1:0]           ram_dout,
  input  logic                           ram_tx_valid
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [IDW-1:0]         r_ptr;
  logic                   r_rd;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [MEM_WIDTH-1:0]   r_wdata;
  logic [IDW-1:0]         r_id;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rsp_valid;
  logic [IDW-1:0]         r_rsp_id;
  logic [MEM_WIDTH-1:0]   r_rsp_rdata;
  logic                   r_rsp_err;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDW-1:0]         w_grant_idx;
  logic                   w_hs;
  logic                   w_sel_rd;
  logic [ADDR_SIZE-1:0]   w_sel_addr;
  logic [MEM_WIDTH-1:0]   w_sel_wdata;
  logic                   w_timeout;
  logic                   w_reuse_hit;

  // Grants only in IDLE and never while reset is held, so req_ready is
  // quiet during reset even if requesters keep req_valid up.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    ((r_state == S_IDLE) && rst_n),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_hs      = |w_grant;

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grant_idx = IDW'(i);
    end
  end

  assign w_sel_rd    = req_rd[w_grant_idx];
  assign w_sel_addr  = req_addr[int'(w_grant_idx)*ADDR_SIZE +: ADDR_SIZE];
  assign w_sel_wdata = req_wdata[int'(w_grant_idx)*MEM_WIDTH +: MEM_WIDTH];

  // Last wait cycle with no data: the response goes out as an error.
  assign w_timeout = (r_state == S_WAIT_RD) && !ram_tx_valid &&
                     (r_cnt == CNT_W'(RD_TIMEOUT - 1));

`ifdef ADDR_REUSE_EN
  logic [ADDR_SIZE-1:0] r_last_wr_addr;
  logic [ADDR_SIZE-1:0] r_last_rd_addr;
  logic                 r_last_wr_vld;
  logic                 r_last_rd_vld;

  // The tracked copy follows whatever the RAM last latched per op type.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr_addr <= '0;
      r_last_rd_addr <= '0;
      r_last_wr_vld  <= 1'b0;
      r_last_rd_vld  <= 1'b0;
    end else if (r_state == S_ADDR) begin
      if (r_rd) begin
        r_last_rd_addr <= r_addr;
        r_last_rd_vld  <= 1'b1;
      end else begin
        r_last_wr_addr <= r_addr;
        r_last_wr_vld  <= 1'b1;
      end
    end
  end

  assign w_reuse_hit = w_sel_rd ? (r_last_rd_vld && (r_last_rd_addr == w_sel_addr))
                                : (r_last_wr_vld && (r_last_wr_addr == w_sel_addr));
`else
  assign w_reuse_hit = 1'b0;
`endif

  // Next state and RAM command beat; the command bus is zero outside
  // ADDR and DATA.
  always_comb begin
    w_next_state = r_state;
    ram_din      = '0;
    ram_rx_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) w_next_state = w_reuse_hit ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(r_rd ? OP_RD_ADDR : OP_WR_ADDR), MEM_WIDTH'(r_addr)};
        w_next_state = S_DATA;
      end
      S_DATA: begin
        ram_rx_valid = 1'b1;
        if (r_rd) begin
          ram_din      = {OP_RD_FIRE, {MEM_WIDTH{1'b0}}};
          w_next_state = S_WAIT_RD;
        end else begin
          ram_din      = {OP_WR_DATA, r_wdata};
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (ram_tx_valid || w_timeout) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: the latched payload is reset as well; it is a handful of flops,
  // and it keeps the datapath free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;

      if (w_hs) begin
        r_rd    <= w_sel_rd;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_id    <= w_grant_idx;
        // Search restarts just past the winner.
        r_ptr   <= (w_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDW'(1);
      end

      unique case (r_state)
        S_DATA: begin
          r_cnt <= '0;
          if (!r_rd) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
          end
        end
        S_WAIT_RD: begin
          if (ram_tx_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_rdata <= ram_dout;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter (MEM_WIDTH 8, ADDR_SIZE 8, NUM_REQ 2,
// RD_TIMEOUT 4). A small RAM model decodes the command beats and answers
// read-fire one cycle later unless muted. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_rd;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout = 8'h00;
  logic        ram_tx_valid = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ram_arbiter #(
    .MEM_WIDTH  (8),
    .ADDR_SIZE  (8),
    .NUM_REQ    (2),
    .RD_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
  );

  // RAM model: decodes each command beat mid-cycle; a read-fire is answered
  // with one cycle of tx_valid in the following cycle.
  logic [7:0] mem [256];
  logic [7:0] m_waddr = 8'h00;
  logic [7:0] m_raddr = 8'h00;
  bit         ram_mute = 1'b0;

  always @(negedge clk) begin
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: m_waddr = ram_din[7:0];
        2'b01: mem[m_waddr] = ram_din[7:0];
        2'b10: m_raddr = ram_din[7:0];
        default: begin
          if (!ram_mute) begin
            @(posedge clk); #1;
            ram_dout     = mem[m_raddr];
            ram_tx_valid = 1'b1;
            @(posedge clk); #1;
            ram_tx_valid = 1'b0;
            ram_dout     = 8'h00;
          end
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int p, input logic rd, input logic [7:0] a, input logic [7:0] d);
    req_rd[p]          = rd;
    req_addr[p*8 +: 8]  = a;
    req_wdata[p*8 +: 8] = d;
  endtask

  task automatic test_reset();
    req_valid = 2'b00; req_rd = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b want 00", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", rsp_err); else n_pass++;
    n_total++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); else n_pass++;
    n_total++; if (rsp_id !== 1'b0) $display("FAIL rst_rsp_id: got %b want 0", rsp_id); else n_pass++;
    n_total++; if (ram_din !== 10'h000) $display("FAIL rst_ram_din: got %h want 000", ram_din); else n_pass++;
    n_total++; if (ram_rx_valid !== 1'b0) $display("FAIL rst_rx_valid: got %b want 0", ram_rx_valid); else n_pass++;
    step(); rst_n = 1'b1;
    step(); @(negedge clk);
    n_total++; if (req_ready !== 2'b00) $display("FAIL idle_req_ready: got %b want 00", req_ready); else n_pass++;
    n_total++; if (ram_rx_valid !== 1'b0) $display("FAIL idle_rx_valid: got %b want 0", ram_rx_valid); else n_pass++;
  endtask

  task automatic test_write();
    step(); set_req(0, 1'b0, 8'h12, 8'hA5); req_valid = 2'b01; @(negedge clk);
    n_total++; if (req_ready !== 2'b01) $display("FAIL wr_ready: got %b want 01", req_ready); else n_pass++;
    step(); req_valid = 2'b00; @(negedge clk);
    n_total++; if (ram_din !== 10'h012) $display("FAIL wr_addr_beat: got %h want 012", ram_din); else n_pass++;
    n_total++; if (ram_rx_valid !== 1'b1) $display("FAIL wr_addr_strobe: got %b want 1", ram_rx_valid); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL wr_early_rsp: got %b want 0", rsp_valid); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (ram_din !== 10'h1A5) $display("FAIL wr_data_beat: got %h want 1a5", ram_din); else n_pass++;
    n_total++; if (ram_rx_valid !== 1'b1) $display("FAIL wr_data_strobe: got %b want 1", ram_rx_valid); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_id !== 1'b0) $display("FAIL wr_rsp_id: got %b want 0", rsp_id); else n_pass++;
    n_total++; if (rsp_rdata !== 8'h00) $display("FAIL wr_rsp_rdata: got %h want 00", rsp_rdata); else n_pass++;
    n_total++; if (ram_rx_valid !== 1'b0 || ram_din !== 10'h000) $display("FAIL wr_bus_idle: got %b/%h want 0/000", ram_rx_valid, ram_din); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_read();
    step(); set_req(1, 1'b1, 8'h12, 8'h00); req_valid = 2'b10; @(negedge clk);
    n_total++; if (req_ready !== 2'b10) $display("FAIL rd_ready: got %b want 10", req_ready); else n_pass++;
    step(); req_valid = 2'b00; @(negedge clk);
    n_total++; if (ram_din !== 10'h212) $display("FAIL rd_addr_beat: got %h want 212", ram_din); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (ram_din !== 10'h300) $display("FAIL rd_fire_beat: got %h want 300", ram_din); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rd_early_rsp: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (ram_rx_valid !== 1'b0) $display("FAIL rd_wait_strobe: got %b want 0", ram_rx_valid); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_id !== 1'b1) $display("FAIL rd_rsp_id: got %b want 1", rsp_id); else n_pass++;
    n_total++; if (rsp_rdata !== 8'hA5) $display("FAIL rd_rsp_rdata: got %h want a5", rsp_rdata); else n_pass++;
    n_total++; if (rsp_err !== 1'b0) $display("FAIL rd_rsp_err: got %b want 0", rsp_err); else n_pass++;
  endtask

  // Both ports always valid: grants alternate and every write back-to-back
  // takes 3 cycles, the next handshake landing in the rsp_valid cycle.
  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    step(); set_req(0, 1'b0, 8'h20, 8'h11); set_req(1, 1'b0, 8'h21, 8'h22); req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      n_total++; if (req_ready !== exp_gnt) $display("FAIL rr_grant_%0d: got %b want %b", i, req_ready, exp_gnt); else n_pass++;
      if (i > 0) begin
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL rr_rsp_valid_%0d: got %b want 1", i, rsp_valid); else n_pass++;
        n_total++; if (rsp_id !== 1'((i - 1) % 2)) $display("FAIL rr_rsp_id_%0d: got %b want %0d", i, rsp_id, (i - 1) % 2); else n_pass++;
      end
      step(); @(negedge clk);
      n_total++; if (req_ready !== 2'b00) $display("FAIL rr_busy_%0d: got %b want 00", i, req_ready); else n_pass++;
      step(); step();
    end
    req_valid = 2'b00; @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL rr_last_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_id !== 1'b1) $display("FAIL rr_last_id: got %b want 1", rsp_id); else n_pass++;
  endtask

  task automatic test_timeout();
    ram_mute = 1'b1;
    step(); set_req(0, 1'b1, 8'h30, 8'h00); req_valid = 2'b01; @(negedge clk);
    n_total++; if (req_ready !== 2'b01) $display("FAIL to_ready: got %b want 01", req_ready); else n_pass++;
    step(); req_valid = 2'b00; @(negedge clk);
    n_total++; if (ram_din !== 10'h230) $display("FAIL to_addr_beat: got %h want 230", ram_din); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (ram_din !== 10'h300) $display("FAIL to_fire_beat: got %h want 300", ram_din); else n_pass++;
    for (int c = 3; c <= 6; c++) begin
      step(); @(negedge clk);
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL to_wait_c%0d: got %b want 0", c, rsp_valid); else n_pass++;
    end
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL to_rsp_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_err !== 1'b1) $display("FAIL to_rsp_err: got %b want 1", rsp_err); else n_pass++;
    n_total++; if (rsp_rdata !== 8'h00) $display("FAIL to_rsp_rdata: got %h want 00", rsp_rdata); else n_pass++;
    n_total++; if (rsp_id !== 1'b0) $display("FAIL to_rsp_id: got %b want 0", rsp_id); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("FAIL to_rsp_pulse: got %b/%b want 0/0", rsp_valid, rsp_err); else n_pass++;
    ram_mute = 1'b0;
  endtask

  // Pointer sits at 1 after the previous grant to port 0; reset in the DATA
  // beat must clear it, so the next contention goes to port 0.
  task automatic test_reset_mid();
    step(); set_req(0, 1'b0, 8'h55, 8'h66); req_valid = 2'b01; @(negedge clk);
    n_total++; if (req_ready !== 2'b01) $display("FAIL rm_ready: got %b want 01", req_ready); else n_pass++;
    step(); req_valid = 2'b00; @(negedge clk);
    n_total++; if (ram_din !== 10'h055) $display("FAIL rm_addr_beat: got %h want 055", ram_din); else n_pass++;
    step(); rst_n = 1'b0; #1;
    n_total++; if (ram_din !== 10'h000) $display("FAIL rm_din: got %h want 000", ram_din); else n_pass++;
    n_total++; if (ram_rx_valid !== 1'b0) $display("FAIL rm_rx_valid: got %b want 0", ram_rx_valid); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rm_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (req_ready !== 2'b00) $display("FAIL rm_req_ready: got %b want 00", req_ready); else n_pass++;
    step(); rst_n = 1'b1; @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rm_no_rsp_c3: got %b want 0", rsp_valid); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rm_no_rsp_c4: got %b want 0", rsp_valid); else n_pass++;
    step(); set_req(1, 1'b0, 8'h56, 8'h77); req_valid = 2'b11; @(negedge clk);
    n_total++; if (req_ready !== 2'b01) $display("FAIL rm_ptr_reset: got %b want 01", req_ready); else n_pass++;
    step(); req_valid = 2'b00; step(); step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) $display("FAIL rm_after_rsp: got %b/%b want 1/0", rsp_valid, rsp_id); else n_pass++;
  endtask

`ifdef ADDR_REUSE_EN
  task automatic test_addr_reuse();
    step(); set_req(0, 1'b0, 8'h40, 8'h01); req_valid = 2'b01; @(negedge clk);
    n_total++; if (req_ready !== 2'b01) $display("FAIL ar_ready1: got %b want 01", req_ready); else n_pass++;
    step(); set_req(0, 1'b0, 8'h40, 8'h02); @(negedge clk);
    n_total++; if (ram_din !== 10'h040) $display("FAIL ar_addr1: got %h want 040", ram_din); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (ram_din !== 10'h101) $display("FAIL ar_data1: got %h want 101", ram_din); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (req_ready !== 2'b01 || rsp_valid !== 1'b1) $display("FAIL ar_hs2: got %b/%b want 01/1", req_ready, rsp_valid); else n_pass++;
    step(); req_valid = 2'b00; @(negedge clk);
    n_total++; if (ram_din !== 10'h102) $display("FAIL ar_skip_addr: got %h want 102", ram_din); else n_pass++;
    step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL ar_rsp2: got %b want 1", rsp_valid); else n_pass++;
    step(); set_req(0, 1'b1, 8'h40, 8'h00); req_valid = 2'b01; @(negedge clk);
    step(); req_valid = 2'b00; @(negedge clk);
    n_total++; if (ram_din !== 10'h240) $display("FAIL ar_rd_addr: got %h want 240", ram_din); else n_pass++;
    step(); step(); step(); @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h02) $display("FAIL ar_rd_rsp: got %b/%h want 1/02", rsp_valid, rsp_rdata); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_timeout();
    test_reset_mid();
`ifdef ADDR_REUSE_EN
    test_addr_reuse();
`endif
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule : tb_ram_arbiter

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port command RAM between NUM_REQ requesters, such as multiple SPI slave front-ends or a debug port. It accepts one transaction at a time, chosen by round-robin. Each transaction is expanded into the RAM's two-beat command sequence: an address beat, then a data or read beat. Read data is returned to the owning requester, tagged with its ID. The block sits directly in front of the RAM and drives its din/rx_valid inputs.

## Interface
- MEM_WIDTH, 8, data width; RAM din width is MEM_WIDTH+2
- ADDR_SIZE, 8, address width; must be ≤ MEM_WIDTH
- NUM_REQ, 2, number of requesters (2..4)
- RD_TIMEOUT, 4, cycles to wait for ram_tx_valid before an error response
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-port request valid
- req_ready  out  NUM_REQ  per-port accept; at most one bit high
- req_rd  in  NUM_REQ  per-port op: 1 = read, 0 = write
- req_addr  in  NUM_REQ*ADDR_SIZE  per-port address; port i at [i*ADDR_SIZE +: ADDR_SIZE]
- req_wdata  in  NUM_REQ*MEM_WIDTH  per-port write data, packed the same way
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  $clog2(NUM_REQ)  port index of the completed transaction
- rsp_rdata  out  MEM_WIDTH  read data; 0 for writes and on error
- rsp_err  out  1  read timeout flag, valid with rsp_valid
- ram_din  out  MEM_WIDTH+2  RAM command: [9:8] opcode, [7:0] payload
- ram_rx_valid  out  1  RAM command strobe
- ram_dout  in  MEM_WIDTH  RAM read data
- ram_tx_valid  in  1  RAM read data valid

## Operation
- Opcodes on ram_din[9:8]:
  - 00: write-address
  - 01: write-data
  - 10: read-address
  - 11: read-fire
- FSM states: IDLE, ADDR, DATA, WAIT_RD.
- IDLE
  - req_ready is combinational: it goes to the round-robin winner among req_valid.
  - On handshake: latch op, addr, wdata and id; go to ADDR.
- ADDR
  - ram_din = {rd, 1'b0, addr zero-extended}, ram_rx_valid = 1.
  - Go to DATA.
- DATA
  - Write: ram_din = {2'b01, wdata}; next state IDLE; rsp_valid is set next cycle.
  - Read: ram_din = {2'b11, 0}; next state WAIT_RD; timeout counter cleared.
- WAIT_RD
  - If ram_tx_valid: capture ram_dout into rsp_rdata, set rsp_valid with rsp_err = 0, go to IDLE.
  - Otherwise the counter increments. When it reaches RD_TIMEOUT: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, go to IDLE.
- Outside ADDR and DATA: ram_rx_valid = 0 and ram_din = 0.
- Round-robin: the priority pointer resets to port 0. After a grant to port i, the search starts at port i+1 (mod NUM_REQ).
- Requests arriving while the block is busy are held off by req_ready = 0. Requesters keep req_valid and the payload stable until accepted.
- ram_tx_valid outside WAIT_RD is ignored.

## Timing
- Reset values:
  - state = IDLE, pointer = 0
  - req_ready = 0 (stays 0 while no req_valid)
  - rsp_valid, rsp_err, rsp_rdata, rsp_id = 0
  - ram_din = 0, ram_rx_valid = 0
- Handshake in cycle 0:
  - Write: ADDR beat in cycle 1, DATA beat in cycle 2, rsp_valid in cycle 3.
  - Read: ADDR in 1, read-fire in 2, ram_tx_valid expected in 3, rsp_valid in 4.
- In the rsp_valid cycle the FSM is in IDLE and can accept the next request. Back-to-back writes therefore take 3 cycles each.
- rsp outputs are registered. rsp_valid is a one-cycle pulse and no response back-pressure exists.
- Reset mid-transaction:
  - Aborts immediately and drops ram_rx_valid.
  - No response is issued for the aborted request.

## Configuration
- ADDR_REUSE_EN defined:
  - The block tracks the last address sent with opcode 00 and with opcode 10, each with a valid bit. Both valid bits are cleared on reset.
  - If a granted request's address matches the tracked address for its op type and that entry is valid, the ADDR beat is skipped and IDLE goes directly to DATA.
  - Latency then drops by 1: write rsp in cycle 2, read rsp in cycle 3.
  - The tracked address is updated on every issued ADDR beat.
- ADDR_REUSE_EN undefined: the ADDR beat is always issued and latencies are as in Timing.

## Structure
- ram_ctrl_pkg:
  - FSM state enum
  - opcode constants OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_FIRE
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer, and a grant-enable; output one-hot grant. Pointer update stays in the parent.

## Test plan
- Port 0 writes addr 0x12 with data 0xA5 → ram_din is 0x012 in cycle 1 and 0x1A5 in cycle 2; rsp_valid with id 0 in cycle 3.
- Port 1 reads 0x12 after the write above, with the RAM model attached → ram_din 0x212 then 0x300; rsp_rdata = 0xA5, id 1, err 0, in cycle 4.
- Both ports assert valid continuously → grants alternate 0,1,0,1 and no port is granted twice in a row.
- RAM model withholds tx_valid → rsp_err = 1 and rsp_rdata = 0 exactly RD_TIMEOUT cycles after WAIT_RD entry.
- Reset asserted in the DATA cycle of a write → all outputs are 0 in the same cycle and no rsp_valid follows; pointer returns to 0.
- With ADDR_REUSE_EN, two writes to 0x40 → the second issues only 0x1xx and completes in 2 cycles; a read from 0x40 still issues its ADDR beat.
